// File: rtl/dice_race_pkg.sv
// Shared types and constants for the dice race board: tile width, event codes
// and the token move sequencer state encoding.
package dice_race_pkg;

  localparam int unsigned POS_W = 4;
  localparam logic [POS_W-1:0] MAX_POS = 4'd10;

  localparam logic [3:0] EVT_NONE          = 4'd0;
  localparam logic [3:0] EVT_NORMAL        = 4'd1;
  localparam logic [3:0] EVT_BACK_TO_START = 4'd3;
  localparam logic [3:0] EVT_WIN           = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP_WAIT,
    S_MOVE_DONE,
    S_EVT_SAMPLE,
    S_EVENT_HOLD,
    S_EVT_DONE
  } seq_state_t;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] pos);
    return (pos > MAX_POS) ? MAX_POS : pos;
  endfunction

  // One tile toward tgt, saturating at 0 and MAX_POS.
  function automatic logic [POS_W-1:0] step_toward(input logic [POS_W-1:0] cur,
                                                   input logic [POS_W-1:0] tgt);
    logic [POS_W-1:0] res;
    res = cur;
    if (cur < tgt && cur != MAX_POS) res = cur + 4'd1;
    else if (cur > tgt && cur != 4'd0) res = cur - 4'd1;
    return res;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; tick is high while the count sits at zero.
// Shared by the step, event-hold and event-sample waits of the sequencer.
module step_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            cnt_reg <= '0;
    else if (load)           cnt_reg <= load_val;
    else if (cnt_reg != '0)  cnt_reg <= cnt_reg - 1'b1;
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/token_move_sequencer.sv
// Paces displayed token movement one tile per STEP_CYCLES and holds event animations,
// answering the game FSM with a one-cycle turn_done. Optional watchdog: SEQ_WATCHDOG_EN.
module token_move_sequencer
  import dice_race_pkg::*;
#(
  parameter int unsigned STEP_CYCLES    = 25_000_000,
  parameter int unsigned EVENT_CYCLES   = 50_000_000,
  parameter int unsigned EVT_SAMPLE_DLY = 2,
  parameter int unsigned WDOG_CYCLES    = 400_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] p1_pos,
  input  logic [3:0] p2_pos,
  input  logic       pos_valid,
  input  logic       turn,
  input  logic [3:0] event_flag,
  output logic [3:0] disp_p1_pos,
  output logic [3:0] disp_p2_pos,
  output logic       mover_id,
  output logic       moving,
  output logic       event_active,
  output logic [3:0] event_code,
  output logic       turn_done,
  output logic       busy,
  output logic       wdog_flag
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVENT_LOAD  = CNT_W'(EVENT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(EVT_SAMPLE_DLY - 1);

  seq_state_t state_reg, state_next;
  logic             pos_valid_prev_reg;
  logic             mover_reg, mover_next;
  logic [POS_W-1:0] target_reg, target_next;
  logic [3:0]       event_code_reg, event_code_next;
  logic             in_event_reg, in_event_next;

  logic             trigger;
  logic             step_mover;
  logic             snap_mover;
  logic             wdog_trip;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_tick;
  logic [1:0][POS_W-1:0] disp_all;
  logic [POS_W-1:0] cur_disp;
  logic [POS_W-1:0] stepped_pos;
  logic [POS_W-1:0] turn_target;
  logic [POS_W-1:0] mover_target;

  assign trigger      = (state_reg == S_IDLE) && pos_valid && !pos_valid_prev_reg;
  assign turn_target  = clamp_pos(turn ? p2_pos : p1_pos);
  assign mover_target = clamp_pos(mover_reg ? p2_pos : p1_pos);
  assign cur_disp     = disp_all[mover_reg];
  assign stepped_pos  = step_toward(cur_disp, target_reg);

  step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (timer_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= S_IDLE;
      pos_valid_prev_reg <= 1'b0;
      mover_reg          <= 1'b0;
      target_reg         <= '0;
      event_code_reg     <= '0;
      in_event_reg       <= 1'b0;
    end else begin
      state_reg          <= state_next;
      pos_valid_prev_reg <= pos_valid;
      mover_reg          <= mover_next;
      target_reg         <= target_next;
      event_code_reg     <= event_code_next;
      in_event_reg       <= in_event_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    mover_next      = mover_reg;
    target_next     = target_reg;
    event_code_next = event_code_reg;
    in_event_next   = in_event_reg;
    step_mover      = 1'b0;
    snap_mover      = 1'b0;
    timer_load      = 1'b0;
    timer_val       = STEP_LOAD;

    unique case (state_reg)
      S_IDLE: begin
        in_event_next = 1'b0;
        if (trigger) begin
          mover_next  = turn;
          target_next = turn_target;
          timer_load  = 1'b1;
          state_next  = (turn_target == disp_all[turn]) ? S_MOVE_DONE : S_STEP_WAIT;
        end
      end
      S_STEP_WAIT: begin
        if (timer_tick) begin
          step_mover = 1'b1;
          if (stepped_pos == target_reg)
            state_next = in_event_reg ? S_EVT_DONE : S_MOVE_DONE;
          else
            timer_load = 1'b1;
        end
      end
      S_MOVE_DONE: begin
        timer_load = 1'b1;
        timer_val  = SAMPLE_LOAD;
        state_next = S_EVT_SAMPLE;
      end
      S_EVT_SAMPLE: begin
        if (timer_tick) begin
          case (event_flag)
            EVT_NONE, EVT_NORMAL, EVT_WIN: state_next = S_IDLE;
            4'd2, EVT_BACK_TO_START, 4'd4, 4'd6, 4'd8: begin
              event_code_next = event_flag;
              target_next     = mover_target;
              in_event_next   = 1'b1;
              timer_load      = 1'b1;
              timer_val       = EVENT_LOAD;
              state_next      = S_EVENT_HOLD;
            end
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_EVENT_HOLD: begin
        if (timer_tick) begin
          if (target_reg != cur_disp) begin
            timer_load = 1'b1;
            state_next = S_STEP_WAIT;
          end else begin
            state_next = S_EVT_DONE;
          end
        end
      end
      S_EVT_DONE: begin
        event_code_next = '0;
        in_event_next   = 1'b0;
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // A stuck sequence is closed out through the event-done pulse.
    if (wdog_trip) begin
      step_mover = 1'b0;
      snap_mover = 1'b1;
      timer_load = 1'b0;
      state_next = S_EVT_DONE;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    logic [POS_W-1:0] disp_reg, disp_next;
    logic [POS_W-1:0] port_pos;

    assign port_pos = (gi == 0) ? p1_pos : p2_pos;

    // The mover's display is held on the trigger cycle so the walk starts from the old tile.
    always_comb begin
      disp_next = disp_reg;
      if (state_reg == S_IDLE) begin
        if (!(trigger && turn == 1'(gi))) disp_next = port_pos;
      end else if (mover_reg == 1'(gi)) begin
        if (snap_mover)      disp_next = target_reg;
        else if (step_mover) disp_next = stepped_pos;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) disp_reg <= '0;
      else          disp_reg <= disp_next;
    end

    assign disp_all[gi] = disp_reg;
  end

`ifdef SEQ_WATCHDOG_EN
  // Trip two counts early so the closing turn_done lands on busy cycle WDOG_CYCLES.
  localparam logic [CNT_W-1:0] WDOG_TRIP = CNT_W'(WDOG_CYCLES - 2);
  logic [CNT_W-1:0] wdog_cnt_reg;
  logic             wdog_flag_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_reg  <= '0;
      wdog_flag_reg <= 1'b0;
    end else begin
      if (state_reg == S_IDLE)    wdog_cnt_reg <= '0;
      else if (wdog_cnt_reg != '1) wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
      if (wdog_trip) wdog_flag_reg <= 1'b1;
    end
  end

  assign wdog_trip = (state_reg == S_STEP_WAIT || state_reg == S_EVT_SAMPLE ||
                      state_reg == S_EVENT_HOLD) && (wdog_cnt_reg >= WDOG_TRIP);
  assign wdog_flag = wdog_flag_reg;
`else
  logic [CNT_W-1:0] wdog_limit_unused;
  assign wdog_limit_unused = CNT_W'(WDOG_CYCLES);
  assign wdog_trip = 1'b0;
  assign wdog_flag = 1'b0;
`endif

  assign disp_p1_pos  = disp_all[0];
  assign disp_p2_pos  = disp_all[1];
  assign mover_id     = mover_reg;
  assign moving       = (state_reg == S_STEP_WAIT);
  assign event_active = (state_reg == S_EVENT_HOLD);
  assign event_code   = event_code_reg;
  assign turn_done    = (state_reg == S_MOVE_DONE) || (state_reg == S_EVT_DONE);
  assign busy         = (state_reg != S_IDLE);

endmodule
